// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its edge feeder: default
// geometry, the feeder state encoding and counter-width helpers.
package systolic_pkg;

  // Default geometry shared by the feeder and the PE array.
  localparam int N_DEF   = 8;  // signed element width
  localparam int DIM_DEF = 4;  // array is DIM x DIM
  localparam int K_DEF   = 4;  // beats per job (inner dimension)

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } feeder_state_t;

  // beat_cnt must hold 0..K.
  function automatic int beat_cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

  // flush_cnt must hold 0..2*(DIM-1).
  function automatic int flush_cnt_w(input int dim);
    return $clog2(2 * dim);
  endfunction

  localparam int BEAT_CNT_W  = beat_cnt_w(K_DEF);
  localparam int FLUSH_CNT_W = flush_cnt_w(DIM_DEF);

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register pipeline used to skew one edge lane of the array.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  // Shift the lane one stage per cycle; stage 0 takes the injected value.
  // NOTE: every stage is reset, not just the head, so a reset mid-job never
  // lets stale operands drain into the PE accumulators afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      // NOTE: non-blocking assignments make all stages sample their
      // predecessor's old value, so the loop order does not matter.
      stage[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// West/north edge feeder for the systolic array: accepts one A column and
// one B row per beat, zero-fills idle cycles, skews lane i by i+1 cycles and
// signals when the far-corner PE has absorbed the job's last product.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DIM = DIM_DEF,
  parameter int K   = K_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DIM-1:0][N-1:0] in_a,
  input  logic signed [DIM-1:0][N-1:0] in_b,
  output logic signed [DIM-1:0][N-1:0] x_out,
  output logic signed [DIM-1:0][N-1:0] y_out,
  output logic                        busy,
  output logic                        done
);

  localparam int BW        = beat_cnt_w(K);
  localparam int FW        = flush_cnt_w(DIM);
  // Cycles from the first flush cycle until the far corner holds the result.
  localparam int FLUSH_LEN = 2 * (DIM - 1) + 1;

  localparam logic [BW-1:0] LAST_BEAT  = BW'(K - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  feeder_state_t state, next_state;
  logic [BW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          accept;

  logic signed [DIM-1:0][N-1:0] inj_a, inj_b;

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: beats advance IDLE/FEED, flush length times FLUSH.
  // NOTE: next_state defaults to state first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = (K == 1) ? FLUSH : FEED;
      FEED:    if (accept && (beat_cnt == LAST_BEAT)) next_state = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status outputs depend on state only.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      FEED:    begin in_ready = 1'b1; busy = 1'b1; end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Beat counter (first beat of a job loads 1) and flush-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept)
        beat_cnt <= (state == IDLE) ? BW'(1) : beat_cnt + 1'b1;
      else if (state == DONE)
        beat_cnt <= '0;

      if (state == FLUSH)
        flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + 1'b1;
      else
        flush_cnt <= '0;
    end
  end

  // Zero injection: any cycle without an accepted beat feeds 0x0 pairs.
  always_comb begin
    inj_a = accept ? in_a : '0;
    inj_b = accept ? in_b : '0;
  end

  // Lane i of both edges is delayed by i+1 registers.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_delay_line #(
      .WIDTH (N),
      .DEPTH (i + 1)
    ) u_skew_a (
      .clk  (clk),
      .rst  (rst),
      .din  (inj_a[i]),
      .dout (x_out[i])
    );

    skew_delay_line #(
      .WIDTH (N),
      .DEPTH (i + 1)
    ) u_skew_b (
      .clk  (clk),
      .rst  (rst),
      .din  (inj_b[i]),
      .dout (y_out[i])
    );
  end

endmodule
